// File: rtl/cic_comb_chain_if.sv
// Sample bus for the CIC comb chain: input strobe/tag/data plus clear,
// and the registered output strobe/tag/data coming back.
interface cic_comb_chain_if #(
  parameter int IW  = 5,
  parameter int OW  = 10,
  parameter int CHW = 1
);
  logic           i_valid;
  logic [CHW-1:0] i_ch;
  logic [IW-1:0]  i_data;
  logic           i_clear;
  logic           o_valid;
  logic [CHW-1:0] o_ch;
  logic [OW-1:0]  o_data;

  modport master (
    output i_valid, i_ch, i_data, i_clear,
    input  o_valid, o_ch, o_data
  );

  modport slave (
    input  i_valid, i_ch, i_data, i_clear,
    output o_valid, o_ch, o_data
  );
endinterface

// File: rtl/cic_comb_chain.sv
// Cascaded, time-multiplexed CIC comb section. Each stage computes
// y = x - x[n-M] per channel with modulo-2^OW arithmetic (wrap is intended).
// History lives in flops, so a same-channel sample in the next cycle already
// sees the value written on the previous edge; no explicit bypass is needed.
module cic_comb_chain #(
  parameter int IW  = 5,
  parameter int OW  = 10,
  parameter int NS  = 3,
  parameter int M   = 1,
  parameter int NCH = 2,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  cic_comb_chain_if.slave bus
);
  localparam int PW = (M > 1) ? $clog2(M) : 1;

  typedef logic [OW-1:0] word_t;

  logic [IW-1:0]  din;
  logic           ch_ok;

  logic [NS-1:0]  stg_vld;
  logic [CHW-1:0] stg_ch  [NS];
  word_t          stg_dat [NS];

  logic [NS-1:0]  vld_q, vld_d;
  logic [CHW-1:0] ch_q  [NS];
  logic [CHW-1:0] ch_d  [NS];
  word_t          dat_q [NS];
  word_t          dat_d [NS];
  word_t          hist_q [NS][NCH][M];
  word_t          hist_d [NS][NCH][M];
  logic [PW-1:0]  ptr_q  [NS][NCH];
  logic [PW-1:0]  ptr_d  [NS][NCH];

  assign din   = bus.i_data;
  // Out-of-range channel tags are dropped before they touch any history.
  assign ch_ok = ({1'b0, bus.i_ch} < (CHW+1)'(NCH));

  assign stg_vld[0] = bus.i_valid & ch_ok;
  assign stg_ch[0]  = bus.i_ch;
  assign stg_dat[0] = OW'($signed(din));

  for (genvar k = 1; k < NS; k++) begin : g_link
    assign stg_vld[k] = vld_q[k-1];
    assign stg_ch[k]  = ch_q[k-1];
    assign stg_dat[k] = dat_q[k-1];
  end

  // Next state for every stage: difference, history write and pointer advance.
  always_comb begin
    vld_d  = '0;
    ch_d   = ch_q;
    dat_d  = dat_q;
    hist_d = hist_q;
    ptr_d  = ptr_q;
    for (int k = 0; k < NS; k++) begin
      if (stg_vld[k]) begin
        vld_d[k] = 1'b1;
        ch_d[k]  = stg_ch[k];
        dat_d[k] = stg_dat[k] - hist_q[k][stg_ch[k]][ptr_q[k][stg_ch[k]]];
        hist_d[k][stg_ch[k]][ptr_q[k][stg_ch[k]]] = stg_dat[k];
        ptr_d[k][stg_ch[k]] = (ptr_q[k][stg_ch[k]] == PW'(M-1)) ?
                              '0 : ptr_q[k][stg_ch[k]] + 1'b1;
      end
    end
  end

  // State update; clear wipes history and in-flight samples, reset also the output words.
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_clear) begin
      vld_q <= '0;
      for (int k = 0; k < NS; k++) begin
        for (int c = 0; c < NCH; c++) begin
          ptr_q[k][c] <= '0;
          for (int m = 0; m < M; m++) begin
            hist_q[k][c][m] <= '0;
          end
        end
      end
      if (i_reset) begin
        for (int k = 0; k < NS; k++) begin
          ch_q[k]  <= '0;
          dat_q[k] <= '0;
        end
      end
    end else begin
      vld_q  <= vld_d;
      ch_q   <= ch_d;
      dat_q  <= dat_d;
      hist_q <= hist_d;
      ptr_q  <= ptr_d;
    end
  end

  assign bus.o_valid = vld_q[NS-1];
  assign bus.o_ch    = ch_q[NS-1];
  assign bus.o_data  = dat_q[NS-1];
endmodule

// File: tb/tb_cic_comb_chain.sv
// Directed bench for cic_comb_chain: six configurations, each driven with a
// hand-computed vector set; outputs are captured with their cycle stamps.
module tb_cic_comb_chain;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int cyc;
    int ch;
    int data;
  } obs_t;

  obs_t q1[$], q2[$], q3[$], q4[$], q5[$], q6[$];
  int   ic1[$], ic2[$], ic3[$], ic4[$], ic5[$], ic6[$];
  int   ed[$], ec[$];

  int d1[5] = '{3, 5, 2, 9, 4};
  int c1[5] = '{0, 0, 0, 1, 0};
  int d4[6] = '{1, 10, 1, 20, 1, 30};

  cic_comb_chain_if #(.IW(5), .OW(10), .CHW(1)) if1 ();
  cic_comb_chain_if #(.IW(5), .OW(10), .CHW(1)) if2 ();
  cic_comb_chain_if #(.IW(5), .OW(10), .CHW(1)) if3 ();
  cic_comb_chain_if #(.IW(6), .OW(10), .CHW(1)) if4 ();
  cic_comb_chain_if #(.IW(5), .OW(5),  .CHW(1)) if5 ();
  cic_comb_chain_if #(.IW(5), .OW(10), .CHW(1)) if6 ();

  cic_comb_chain #(.IW(5), .OW(10), .NS(1), .M(1), .NCH(1)) u1 (.i_clk(clk), .i_reset(rst), .bus(if1.slave));
  cic_comb_chain #(.IW(5), .OW(10), .NS(3), .M(1), .NCH(1)) u2 (.i_clk(clk), .i_reset(rst), .bus(if2.slave));
  cic_comb_chain #(.IW(5), .OW(10), .NS(1), .M(2), .NCH(1)) u3 (.i_clk(clk), .i_reset(rst), .bus(if3.slave));
  cic_comb_chain #(.IW(6), .OW(10), .NS(1), .M(1), .NCH(2)) u4 (.i_clk(clk), .i_reset(rst), .bus(if4.slave));
  cic_comb_chain #(.IW(5), .OW(5),  .NS(1), .M(1), .NCH(1)) u5 (.i_clk(clk), .i_reset(rst), .bus(if5.slave));
  cic_comb_chain #(.IW(5), .OW(10), .NS(2), .M(1), .NCH(1)) u6 (.i_clk(clk), .i_reset(rst), .bus(if6.slave));

  // Output capture, sampled on the falling edge.
  always @(negedge clk) begin
    if (if1.o_valid) q1.push_back('{cyc, int'(if1.o_ch), int'($signed(if1.o_data))});
    if (if2.o_valid) q2.push_back('{cyc, int'(if2.o_ch), int'($signed(if2.o_data))});
    if (if3.o_valid) q3.push_back('{cyc, int'(if3.o_ch), int'($signed(if3.o_data))});
    if (if4.o_valid) q4.push_back('{cyc, int'(if4.o_ch), int'($signed(if4.o_data))});
    if (if5.o_valid) q5.push_back('{cyc, int'(if5.o_ch), int'($signed(if5.o_data))});
    if (if6.o_valid) q6.push_back('{cyc, int'(if6.o_ch), int'($signed(if6.o_data))});
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_stream(input string tag, input obs_t got[$], input int exp_d[$],
                              input int exp_c[$], input int in_c[$], input int lat);
    check_eq({tag, " count"}, got.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got.size(); i++) begin
      check_eq($sformatf("%s data[%0d]", tag, i), got[i].data, exp_d[i]);
      check_eq($sformatf("%s ch[%0d]", tag, i), got[i].ch, exp_c[i]);
      check_eq($sformatf("%s latency[%0d]", tag, i), got[i].cyc - in_c[i], lat);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if1.i_valid = 0; if1.i_ch = '0; if1.i_data = '0; if1.i_clear = 0;
    if2.i_valid = 0; if2.i_ch = '0; if2.i_data = '0; if2.i_clear = 0;
    if3.i_valid = 0; if3.i_ch = '0; if3.i_data = '0; if3.i_clear = 0;
    if4.i_valid = 0; if4.i_ch = '0; if4.i_data = '0; if4.i_clear = 0;
    if5.i_valid = 0; if5.i_ch = '0; if5.i_data = '0; if5.i_clear = 0;
    if6.i_valid = 0; if6.i_ch = '0; if6.i_data = '0; if6.i_clear = 0;
    repeat (3) step();

    check_eq("reset o_valid", int'(if2.o_valid), 0);
    check_eq("reset o_data", int'(if2.o_data), 0);
    check_eq("reset o_ch", int'(if4.o_ch), 0);
    rst = 1'b0;
    step();

    // NS=1 M=1: 3,5,2 -> 3,2,-3; out-of-range tag dropped; then 4 -> 4-2.
    for (int i = 0; i < 5; i++) begin
      step();
      if1.i_valid = 1'b1; if1.i_ch = 1'(c1[i]); if1.i_data = 5'(d1[i]);
      if (c1[i] == 0) ic1.push_back(cyc);
    end
    step(); if1.i_valid = 1'b0;
    repeat (3) step();
    ed = {3, 2, -3, 2}; ec = {0, 0, 0, 0};
    check_stream("t1", q1, ed, ec, ic1, 1);

    // NS=3: constant 1 -> 1,-2,1,0,0,0.
    for (int i = 0; i < 6; i++) begin
      step(); if2.i_valid = 1'b1; if2.i_data = 5'd1; ic2.push_back(cyc);
    end
    step(); if2.i_valid = 1'b0;
    repeat (5) step();
    ed = {1, -2, 1, 0, 0, 0}; ec = {0, 0, 0, 0, 0, 0};
    check_stream("t2", q2, ed, ec, ic2, 3);

    // M=2 with idle gaps: 1,2,3,4 -> 1,2,2,2.
    for (int i = 0; i < 4; i++) begin
      step(); if3.i_valid = 1'b1; if3.i_data = 5'(i + 1); ic3.push_back(cyc);
      step(); if3.i_valid = 1'b0;
      step();
    end
    repeat (3) step();
    ed = {1, 2, 2, 2}; ec = {0, 0, 0, 0};
    check_stream("t3", q3, ed, ec, ic3, 1);

    // Two interleaved channels with independent history.
    for (int i = 0; i < 6; i++) begin
      step(); if4.i_valid = 1'b1; if4.i_ch = 1'(i % 2); if4.i_data = 6'(d4[i]); ic4.push_back(cyc);
    end
    step(); if4.i_valid = 1'b0;
    repeat (3) step();
    ed = {1, 10, 0, 10, 0, 10}; ec = {0, 1, 0, 1, 0, 1};
    check_stream("t4", q4, ed, ec, ic4, 1);

    // OW=IW=5 wrap: -16, 15 -> -16, -1.
    step(); if5.i_valid = 1'b1; if5.i_data = 5'(-16); ic5.push_back(cyc);
    step(); if5.i_data = 5'd15; ic5.push_back(cyc);
    step(); if5.i_valid = 1'b0;
    repeat (3) step();
    ed = {-16, -1}; ec = {0, 0};
    check_stream("t5", q5, ed, ec, ic5, 1);

    // NS=2 stream of 5s, clear alongside the 4th sample.
    for (int i = 0; i < 6; i++) begin
      step();
      if6.i_valid = 1'b1; if6.i_data = 5'd5; if6.i_clear = (i == 3);
      if (i != 2 && i != 3) ic6.push_back(cyc);
      if (i == 4) check_eq("t6 o_valid after clear", int'(if6.o_valid), 0);
      if (i == 5) check_eq("t6 o_valid flushed", int'(if6.o_valid), 0);
    end
    step(); if6.i_valid = 1'b0;
    repeat (4) step();
    ed = {5, -5, 5, -5}; ec = {0, 0, 0, 0};
    check_stream("t6", q6, ed, ec, ic6, 2);

    // Reset mid-stream on the NS=1 unit: 7 after 4 -> 3, then reset, then 6 -> 6.
    q1.delete(); ic1.delete();
    step(); if1.i_valid = 1'b1; if1.i_ch = 1'b0; if1.i_data = 5'd7; ic1.push_back(cyc);
    step(); if1.i_data = 5'd8; rst = 1'b1;
    step(); rst = 1'b0; if1.i_valid = 1'b0;
    check_eq("t7 o_valid after reset", int'(if1.o_valid), 0);
    check_eq("t7 o_data after reset", int'(if1.o_data), 0);
    step(); if1.i_valid = 1'b1; if1.i_data = 5'd6; ic1.push_back(cyc);
    step(); if1.i_valid = 1'b0;
    repeat (3) step();
    ed = {3, 6}; ec = {0, 0};
    check_stream("t7", q1, ed, ec, ic1, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
